// File: rtl/dsm_cic_pkg.sv
// Shared sizing helpers for the CIC decimator: log2, accumulator width, ratio check.
// Accumulator width grows by log2(DECIM) bits per stage so integrator wrap cancels in the combs.
package dsm_cic_pkg;

  function automatic int clog2_f(input int v);
    int r;
    r = 0;
    for (int p = 1; p < v; p = p * 2) r++;
    return r;
  endfunction

  function automatic int acc_width_f(input int in_w, input int order, input int decim);
    return in_w + order * clog2_f(decim);
  endfunction

  function automatic bit is_pow2_f(input int v);
    return (v >= 2) && ((v & (v - 1)) == 0);
  endfunction

  localparam int DEF_ACC_W = acc_width_f(4, 3, 16);
  typedef logic signed [DEF_ACC_W-1:0] acc_def_t;

endpackage

// File: rtl/dsm_cic_comb.sv
// One CIC comb stage (M=1): y = x - x_delayed, advancing only when i_en is high.
module dsm_cic_comb
  import dsm_cic_pkg::*;
#(
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic             aclk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic [ACC_W-1:0] i_x,
  output logic [ACC_W-1:0] o_y
);

  logic signed [ACC_W-1:0] r_dly_p0;
  logic signed [ACC_W-1:0] r_y_p0;

  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      r_dly_p0 <= '0;
      r_y_p0   <= '0;
    end else if (i_en) begin
      r_y_p0   <= $signed(i_x) - r_dly_p0;
      r_dly_p0 <= $signed(i_x);
    end
  end

  assign o_y = r_y_p0;

endmodule

// File: rtl/dsm_cic_decimator.sv
// sinc^ORDER CIC decimator for MASH / 1-bit DSM streams with a valid/ready output.
// Define DSM_CIC_ROUND_EN for round-half-up with positive saturation instead of truncation.
module dsm_cic_decimator
  import dsm_cic_pkg::*;
#(
  parameter int IN_WIDTH  = 4,
  parameter int BIT_MODE  = 0,
  parameter int ORDER     = 3,
  parameter int DECIM     = 16,
  parameter int OUT_WIDTH = 16
) (
  input  logic                 aclk,
  input  logic                 rst_n,
  input  logic [IN_WIDTH-1:0]  in_data,
  input  logic                 in_valid,
  output logic [OUT_WIDTH-1:0] m_tdata,
  output logic                 m_tvalid,
  input  logic                 m_tready,
  output logic                 overrun,
  input  logic                 overrun_clr
);

  localparam int LOG2D = clog2_f(DECIM);
  localparam int ACC_W = acc_width_f(IN_WIDTH, ORDER, DECIM);

  if (!is_pow2_f(DECIM)) begin : g_bad_decim
    $error("dsm_cic_decimator: DECIM must be a power of two >= 2");
  end
  if (ORDER < 1 || ORDER > 5) begin : g_bad_order
    $error("dsm_cic_decimator: ORDER must be in 1..5");
  end
  if (OUT_WIDTH > ACC_W) begin : g_bad_width
    $error("dsm_cic_decimator: OUT_WIDTH must not exceed the accumulator width");
  end

`ifdef DSM_CIC_ROUND_EN
  localparam int SH = ACC_W - OUT_WIDTH;
  localparam logic [ACC_W:0] HALF = (SH > 0) ? ((ACC_W + 1)'(1) << ((SH > 0) ? SH - 1 : 0)) : '0;
`endif

  function automatic logic [OUT_WIDTH-1:0] f_quant(input logic [ACC_W-1:0] a);
`ifdef DSM_CIC_ROUND_EN
    logic [ACC_W:0] s;
    s = {a[ACC_W-1], a} + HALF;
    if (s[ACC_W] != s[ACC_W-1]) return {1'b0, {(OUT_WIDTH-1){1'b1}}};
    return s[ACC_W-1 -: OUT_WIDTH];
`else
    return a[ACC_W-1 -: OUT_WIDTH];
`endif
  endfunction

  logic signed [ACC_W-1:0] w_x;
  logic                    w_unused_in;
  assign w_unused_in = ^in_data;

  if (BIT_MODE != 0) begin : g_bit
    assign w_x = in_data[0] ? {{(ACC_W-1){1'b0}}, 1'b1} : {ACC_W{1'b1}};
  end else begin : g_pcm
    assign w_x = {{(ACC_W-IN_WIDTH){in_data[IN_WIDTH-1]}}, in_data};
  end

  // Integrator stage: wrap-around accumulation, advancing only on accepted inputs
  logic signed [ORDER-1:0][ACC_W-1:0] r_int_p0;
  logic [LOG2D-1:0]                   r_cnt;
  // r_stb[0] = decimate strobe; r_stb[k] walks it through capture and comb k
  logic [ORDER+1:0]                   r_stb;

  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      r_int_p0 <= '0;
    end else if (in_valid) begin
      r_int_p0[0] <= r_int_p0[0] + w_x;
      for (int k = 1; k < ORDER; k++) r_int_p0[k] <= r_int_p0[k] + r_int_p0[k-1];
    end
  end

  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_stb <= '0;
    end else begin
      if (in_valid) r_cnt <= r_cnt + 1'b1;
      r_stb <= {r_stb[ORDER:0], in_valid & (&r_cnt)};
    end
  end

  // Capture stage: sample the last integrator at the decimated rate
  logic signed [ACC_W-1:0] r_samp_p1;

  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n)        r_samp_p1 <= '0;
    else if (r_stb[0]) r_samp_p1 <= r_int_p0[ORDER-1];
  end

  // Comb stages
  logic [ORDER:0][ACC_W-1:0] w_comb;
  assign w_comb[0] = r_samp_p1;

  for (genvar g = 0; g < ORDER; g++) begin : g_comb
    dsm_cic_comb #(.ACC_W(ACC_W)) u_comb (
      .aclk  (aclk),
      .rst_n (rst_n),
      .i_en  (r_stb[g+1]),
      .i_x   (w_comb[g]),
      .o_y   (w_comb[g+1])
    );
  end

  // Output stage: valid/ready holding register with sticky overrun
  logic [OUT_WIDTH-1:0] r_tdata_p2;
  logic                 r_tvalid;
  logic                 r_overrun;
  logic                 w_load;
  logic                 w_xfer;
  logic                 w_drop;

  assign w_load = r_stb[ORDER+1];
  assign w_xfer = r_tvalid & m_tready;
  assign w_drop = w_load & r_tvalid & ~m_tready;

  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      r_tdata_p2 <= '0;
      r_tvalid   <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      if (w_load && (!r_tvalid || m_tready)) begin
        r_tdata_p2 <= f_quant(w_comb[ORDER]);
        r_tvalid   <= 1'b1;
      end else if (w_xfer) begin
        r_tvalid   <= 1'b0;
      end
      if (w_drop)           r_overrun <= 1'b1;
      else if (overrun_clr) r_overrun <= 1'b0;
    end
  end

  assign m_tdata  = r_tdata_p2;
  assign m_tvalid = r_tvalid;
  assign overrun  = r_overrun;

endmodule

// File: tb/tb_dsm_cic_decimator.sv
// Directed bench for dsm_cic_decimator: PCM instance (defaults) plus a BIT_MODE instance.
module tb_dsm_cic_decimator;

  logic        aclk = 1'b0;
  logic        rst_n;
  logic [3:0]  in_data;
  logic        in_valid;
  logic        m_tready;
  logic        overrun_clr;
  logic [15:0] m_tdata;
  logic        m_tvalid;
  logic        overrun;
  logic [15:0] b_tdata;
  logic        b_tvalid;
  logic        b_overrun;

  int n_cmp = 0;
  int n_err = 0;
  bit alt_mode = 1'b0;
  bit gap_mode = 1'b0;
  int gap_ph = 0;

  always #5 aclk = ~aclk;

  dsm_cic_decimator u_dut (
    .aclk        (aclk),
    .rst_n       (rst_n),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .m_tdata     (m_tdata),
    .m_tvalid    (m_tvalid),
    .m_tready    (m_tready),
    .overrun     (overrun),
    .overrun_clr (overrun_clr)
  );

  dsm_cic_decimator #(.BIT_MODE(1)) u_bit (
    .aclk        (aclk),
    .rst_n       (rst_n),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .m_tdata     (b_tdata),
    .m_tvalid    (b_tvalid),
    .m_tready    (m_tready),
    .overrun     (b_overrun),
    .overrun_clr (overrun_clr)
  );

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
    if (alt_mode) in_data = in_data ^ 4'd1;
    if (gap_mode) begin
      gap_ph   = (gap_ph == 2) ? 0 : gap_ph + 1;
      in_valid = (gap_ph == 0);
    end
  endtask

  task automatic get_sample(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (m_tvalid !== 1'b1 && n < 200);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst_n = 1'b0; in_data = 4'd0; in_valid = 1'b0; m_tready = 1'b0; overrun_clr = 1'b0;
    tick(); tick();
    chk("rst_tvalid", m_tvalid, 0);
    chk("rst_tdata", $signed(m_tdata), 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_b_tvalid", b_tvalid, 0);

    // constant +1: transient 560, 3280, then 4096
    in_data = 4'd1; in_valid = 1'b1; m_tready = 1'b1; rst_n = 1'b1;
    repeat (16) tick();
    chk("pre_first_valid", m_tvalid, 0);
    get_sample(n);
    chk("first_latency", n, 5);
    chk("out0", $signed(m_tdata), 560);
    chk("b_out0", $signed(b_tdata), 560);
    get_sample(n);
    chk("period16", n, 16);
    chk("out1", $signed(m_tdata), 3280);
    get_sample(n);
    chk("out2", $signed(m_tdata), 4096);
    get_sample(n);
    chk("out3", $signed(m_tdata), 4096);
    chk("b_out3", $signed(b_tdata), 4096);
    chk("b_tvalid_align", b_tvalid, 1);

    in_data = 4'd7;
    repeat (4) get_sample(n);
    chk("p7_period", n, 16);
    chk("p7_data", $signed(m_tdata), 28672);
    chk("b_p7_data", $signed(b_tdata), 4096);

    in_data = 4'b1000;
    repeat (4) get_sample(n);
    chk("m8_data", $signed(m_tdata), -32768);
    chk("b_m8_data", $signed(b_tdata), -4096);

    in_data = 4'd1; alt_mode = 1'b1;
    repeat (4) get_sample(n);
    chk("alt_data", $signed(m_tdata), 2048);
    chk("b_alt_data", $signed(b_tdata), 0);

    alt_mode = 1'b0; in_data = 4'd1;
    repeat (4) get_sample(n);
    chk("steady_data", $signed(m_tdata), 4096);

    // backpressure: hold, overrun, clear-vs-set priority, late transfer
    m_tready = 1'b0;
    repeat (15) tick();
    chk("hold_ovr_pre", overrun, 0);
    tick();
    chk("hold_ovr_set", overrun, 1);
    chk("hold_valid", m_tvalid, 1);
    chk("hold_data", $signed(m_tdata), 4096);
    repeat (15) tick();
    overrun_clr = 1'b1;
    tick();
    chk("ovr_set_wins", overrun, 1);
    tick();
    chk("ovr_cleared", overrun, 0);
    overrun_clr = 1'b0;
    repeat (7) tick();
    chk("hold40_valid", m_tvalid, 1);
    chk("hold40_data", $signed(m_tdata), 4096);
    m_tready = 1'b1;
    tick();
    chk("xfer_drop", m_tvalid, 0);
    get_sample(n);
    chk("post_xfer_gap", n, 7);
    chk("post_xfer_data", $signed(m_tdata), 4096);

    // in_valid every third cycle
    gap_mode = 1'b1; gap_ph = 0; in_valid = 1'b0;
    get_sample(n);
    get_sample(n);
    chk("gap_period_a", n, 48);
    get_sample(n);
    chk("gap_period_b", n, 48);
    chk("gap_data", $signed(m_tdata), 4096);

    // asynchronous reset while a sample is held and overrun is set
    gap_mode = 1'b0; in_valid = 1'b1; m_tready = 1'b0;
    repeat (40) tick();
    chk("pre_rst_valid", m_tvalid, 1);
    chk("pre_rst_ovr", overrun, 1);
    chk("pre_rst_data", $signed(m_tdata), 4096);
    rst_n = 1'b0;
    #2;
    chk("async_valid", m_tvalid, 0);
    chk("async_data", $signed(m_tdata), 0);
    chk("async_ovr", overrun, 0);
    tick();
    in_data = 4'd1; in_valid = 1'b1; m_tready = 1'b1; rst_n = 1'b1;
    repeat (16) tick();
    get_sample(n);
    chk("rst2_latency", n, 5);
    chk("rst2_out0", $signed(m_tdata), 560);
    get_sample(n);
    chk("rst2_out1", $signed(m_tdata), 3280);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
